// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared definitions for the ysyx_22040365 fetch unit: reset PC, widths and FSM state encodings.
package ysyx_22040365_ifu_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [XLEN-1:0] ALIGN_MASK   = ~64'd3;

  typedef enum logic [1:0] {
    IFU_RESET = 2'd0,
    IFU_REQ   = 2'd1,
    IFU_WAIT  = 2'd2,
    IFU_HOLD  = 2'd3
  } ifu_state_e;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: PC owner, single-outstanding imem fetch, decode handshake, redirects.
// Optional performance counters are enabled with `define YSYX_22040365_IFU_PERF_EN.
module ysyx_22040365_ifu
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  output logic              imem_rsp_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc
`ifdef YSYX_22040365_IFU_PERF_EN
  ,
  output logic [XLEN-1:0]   perf_fetch_cnt,
  output logic [XLEN-1:0]   perf_stall_cnt
`endif
);

  ifu_state_e          state;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     addr_q;
  logic                drop;
  logic                stale;
  logic [INST_W-1:0]   inst_q;
  logic [XLEN-1:0]     pc_q;
  logic [XLEN-1:0]     target;

  assign target = align4(redirect_pc);

  // addr_q freezes the request address so a redirect cannot disturb a pending request;
  // stale remembers that the pending request is already outdated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IFU_RESET;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      drop   <= 1'b0;
      stale  <= 1'b0;
      inst_q <= '0;
      pc_q   <= RESET_PC;
    end else begin
      case (state)
        IFU_RESET: begin
          state <= IFU_REQ;
          if (redirect_valid) begin
            pc    <= target;
            stale <= 1'b1;
          end
        end
        IFU_REQ: begin
          if (redirect_valid) pc <= target;
          if (imem_req_ready) begin
            state <= IFU_WAIT;
            drop  <= stale | redirect_valid;
            stale <= 1'b0;
          end else if (redirect_valid) begin
            stale <= 1'b1;
          end
        end
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop || redirect_valid) begin
              drop   <= 1'b0;
              state  <= IFU_REQ;
              pc     <= redirect_valid ? target : pc;
              addr_q <= redirect_valid ? target : pc;
            end else begin
              inst_q <= imem_rdata;
              pc_q   <= pc;
              state  <= IFU_HOLD;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
            pc   <= target;
          end
        end
        IFU_HOLD: begin
          // A redirect wins over +4 even when the instruction is consumed the same cycle.
          if (redirect_valid) begin
            pc     <= target;
            addr_q <= target;
            state  <= IFU_REQ;
          end else if (inst_ready) begin
            pc     <= pc + 64'd4;
            addr_q <= pc + 64'd4;
            state  <= IFU_REQ;
          end
        end
        default: state <= IFU_RESET;
      endcase
    end
  end

  assign imem_req_valid = (state == IFU_REQ);
  assign imem_addr      = addr_q;
  assign imem_rsp_ready = (state == IFU_WAIT);
  assign inst_valid     = (state == IFU_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = pc_q;

`ifdef YSYX_22040365_IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_valid && inst_ready)
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if ((state == IFU_WAIT) || (state == IFU_REQ && !imem_req_ready))
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule
